theta_slice_scheduler: RTL and testbench



---
 rtl/theta_slice_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_theta_slice_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/theta_slice_scheduler.sv
// ---------------------------------------------------------------------------
// theta_slice_scheduler
//
// Turns per-revolution period measurements from the IR/theta counter into
// evenly spaced angular slice events for the column loader.
//
// A three-state lock FSM (UNLOCKED / ACQUIRE / LOCKED) checks that periods
// are in range and stable from one revolution to the next. Once locked,
// each period_ready restarts the revolution. The revolution is split into
// NUM_SLICES slices of period >> SLICE_W cycles each. The last slice also
// takes the truncation remainder. A watchdog drops lock when period_ready
// stops arriving.
//
// Optional feature (macro SLICE_PHASE_OFFSET_EN):
//   adds input phase_offset. It is sampled at each revolution start and
//   added modulo NUM_SLICES to the raw slice index, so the image can be
//   aligned to mechanical zero.
//
// Ports:
//   clk_in        in   system clock
//   rst_n_in      in   asynchronous active-low reset
//   period_ready  in   one-cycle strobe: new period, revolution restarts now
//   period        in   cycles in the last revolution (sampled with strobe)
//   phase_offset  in   slice index offset (only with SLICE_PHASE_OFFSET_EN)
//   slice_valid   out  slice_idx is valid
//   slice_ready   in   consumer accepts the slice this cycle
//   slice_idx     out  registered slice number
//   locked        out  high while in LOCKED
//   overrun_count out  saturating count of slices replaced before acceptance
// ---------------------------------------------------------------------------
module theta_slice_scheduler #(
    parameter int THETA_RES  = 27,
    parameter int SLICE_W    = 6,
    parameter int MIN_PERIOD = 1_000_000,
    parameter int MAX_PERIOD = 100_000_000,
    parameter int TOL_SHIFT  = 4,
    parameter int LOCK_COUNT = 4      // expected >= 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 period_ready,
    input  logic [THETA_RES-1:0] period,
`ifdef SLICE_PHASE_OFFSET_EN
    input  logic [SLICE_W-1:0]   phase_offset,
`endif
    output logic                 slice_valid,
    input  logic                 slice_ready,
    output logic [SLICE_W-1:0]   slice_idx,
    output logic                 locked,
    output logic [7:0]           overrun_count
);

    localparam int LEN_W = THETA_RES - SLICE_W;
    localparam int ACQ_W = $clog2(LOCK_COUNT + 1);

    localparam logic [THETA_RES-1:0] MIN_P  = THETA_RES'(MIN_PERIOD);
    localparam logic [THETA_RES-1:0] MAX_P  = THETA_RES'(MAX_PERIOD);
    localparam logic [THETA_RES-1:0] WD_LIM = THETA_RES'(MAX_PERIOD + 1);
    localparam logic [ACQ_W-1:0]     LOCK_N = ACQ_W'(LOCK_COUNT);
    localparam logic [SLICE_W-1:0]   LAST_IDX = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACQ_W-1:0]     acq_cnt_q, acq_cnt_d;
    logic [THETA_RES-1:0] prev_period_q, prev_period_d;
    logic [THETA_RES-1:0] wdog_q, wdog_d;
    logic [LEN_W-1:0]     slice_len_q, slice_len_d;
    logic [LEN_W-1:0]     in_cnt_q, in_cnt_d;
    logic [SLICE_W-1:0]   raw_idx_q, raw_idx_d;
    logic                 slice_valid_q, slice_valid_d;
    logic [SLICE_W-1:0]   slice_idx_q, slice_idx_d;
    logic [7:0]           overrun_q, overrun_d;

    logic                 period_ok, in_tol, wdog_expired;
    logic [THETA_RES-1:0] diff;
    logic                 start_rev, drop;
    logic [LEN_W-1:0]     len_new;
    logic [SLICE_W-1:0]   phase_new, phase_cur;

    // ---------------- phase offset ----------------
`ifdef SLICE_PHASE_OFFSET_EN
    logic [SLICE_W-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = start_rev ? phase_offset : phase_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) phase_q <= '0;
        else           phase_q <= phase_d;
    end

    // The first slice of a revolution uses the offset being sampled now.
    assign phase_new = phase_offset;
    assign phase_cur = phase_q;
`else
    assign phase_new = '0;
    assign phase_cur = '0;
`endif

    // ---------------- period qualification / watchdog ----------------
    always_comb begin
        period_ok    = (period >= MIN_P) && (period <= MAX_P);
        diff         = (period >= prev_period_q) ? (period - prev_period_q)
                                                 : (prev_period_q - period);
        in_tol       = (diff <= (prev_period_q >> TOL_SHIFT));
        wdog_expired = (wdog_q == WD_LIM);
        len_new      = period[THETA_RES-1:SLICE_W];
        if (len_new == '0) len_new = LEN_W'(1);

        prev_period_d = period_ready ? period : prev_period_q;
        // Loaded with 1 on the strobe, so wdog_q equals the number of cycles
        // elapsed since the last period_ready. It holds at WD_LIM.
        if (period_ready)      wdog_d = THETA_RES'(1);
        else if (wdog_expired) wdog_d = wdog_q;
        else                   wdog_d = wdog_q + THETA_RES'(1);
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d   = state_q;
        acq_cnt_d = acq_cnt_q;
        start_rev = 1'b0;
        unique case (state_q)
            ST_UNLOCKED: begin
                if (period_ready && period_ok) begin
                    state_d   = ST_ACQUIRE;
                    acq_cnt_d = ACQ_W'(1);
                end
            end
            ST_ACQUIRE: begin
                if (period_ready) begin
                    if (period_ok && in_tol) begin
                        acq_cnt_d = acq_cnt_q + ACQ_W'(1);
                        if (acq_cnt_d == LOCK_N) begin
                            state_d   = ST_LOCKED;
                            start_rev = 1'b1;
                        end
                    end else if (period_ok) begin
                        // A valid but jumped period becomes the new reference.
                        acq_cnt_d = ACQ_W'(1);
                    end else begin
                        state_d   = ST_UNLOCKED;
                        acq_cnt_d = '0;
                    end
                end else if (wdog_expired) begin
                    state_d   = ST_UNLOCKED;
                    acq_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (period_ready) begin
                    if (period_ok && in_tol) begin
                        start_rev = 1'b1;
                    end else begin
                        state_d   = ST_UNLOCKED;
                        acq_cnt_d = '0;
                    end
                end else if (wdog_expired) begin
                    state_d   = ST_UNLOCKED;
                    acq_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_UNLOCKED;
                acq_cnt_d = '0;
            end
        endcase
        drop = (state_d == ST_UNLOCKED);
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    // ---------------- slice generator / handshake ----------------
    always_comb begin
        logic pending, boundary, bump;
        pending  = slice_valid_q & ~slice_ready;
        boundary = (state_q == ST_LOCKED) && (raw_idx_q != LAST_IDX) &&
                   (in_cnt_q == slice_len_q);
        bump     = 1'b0;

        slice_len_d   = slice_len_q;
        in_cnt_d      = in_cnt_q;
        raw_idx_d     = raw_idx_q;
        slice_valid_d = pending;          // valid drops after acceptance
        slice_idx_d   = slice_idx_q;
        overrun_d     = overrun_q;

        if (drop) begin
            slice_valid_d = 1'b0;
        end else if (start_rev) begin
            slice_len_d   = len_new;
            in_cnt_d      = LEN_W'(1);
            raw_idx_d     = '0;
            slice_valid_d = 1'b1;
            slice_idx_d   = phase_new;
            bump          = pending;
        end else if (state_q == ST_LOCKED) begin
            if (boundary) begin
                in_cnt_d      = LEN_W'(1);
                raw_idx_d     = raw_idx_q + SLICE_W'(1);
                slice_valid_d = 1'b1;
                slice_idx_d   = raw_idx_q + SLICE_W'(1) + phase_cur;
                bump          = pending;
            end else if (raw_idx_q != LAST_IDX) begin
                // The last slice runs until the next strobe, so the counter
                // freezes there instead of wrapping.
                in_cnt_d = in_cnt_q + LEN_W'(1);
            end
        end

        if (bump && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_UNLOCKED;
            acq_cnt_q     <= '0;
            prev_period_q <= '0;
            wdog_q        <= '0;
            slice_len_q   <= '0;
            in_cnt_q      <= '0;
            raw_idx_q     <= '0;
            slice_valid_q <= 1'b0;
            slice_idx_q   <= '0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            acq_cnt_q     <= acq_cnt_d;
            prev_period_q <= prev_period_d;
            wdog_q        <= wdog_d;
            slice_len_q   <= slice_len_d;
            in_cnt_q      <= in_cnt_d;
            raw_idx_q     <= raw_idx_d;
            slice_valid_q <= slice_valid_d;
            slice_idx_q   <= slice_idx_d;
            overrun_q     <= overrun_d;
        end
    end

    assign slice_valid   = slice_valid_q;
    assign slice_idx     = slice_idx_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_theta_slice_scheduler.sv
// Scoreboard bench for theta_slice_scheduler. It uses scaled-down limits so
// the run stays short: MIN=100, MAX=2000, 64 slices. Period 640 gives
// slice_len 10, 645 also gives 10, and 800 gives 12. Each expected slice
// is queued as {presentation cycle, index}. A monitor checks every
// accepted slice against the head of the queue.
module tb_theta_slice_scheduler;
    localparam int TR = 27;
    localparam int SW = 6;
`ifdef SLICE_PHASE_OFFSET_EN
    localparam int PH = 62;
`else
    localparam int PH = 0;
`endif

    typedef struct { int cyc; int idx; } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          period_ready;
    logic [TR-1:0] period;
    logic          slice_valid;
    logic          slice_ready;
    logic [SW-1:0] slice_idx;
    logic          locked;
    logic [7:0]    overrun_count;
`ifdef SLICE_PHASE_OFFSET_EN
    logic [SW-1:0] phase_offset = SW'(PH);
`endif

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];

    theta_slice_scheduler #(
        .THETA_RES(TR), .SLICE_W(SW), .MIN_PERIOD(100), .MAX_PERIOD(2000),
        .TOL_SHIFT(4), .LOCK_COUNT(4)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .period_ready(period_ready),
        .period(period),
`ifdef SLICE_PHASE_OFFSET_EN
        .phase_offset(phase_offset),
`endif
        .slice_valid(slice_valid), .slice_ready(slice_ready),
        .slice_idx(slice_idx), .locked(locked), .overrun_count(overrun_count)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue slices first..last of a revolution that starts at cycle e.
    task automatic push_rev(input int e, input int len, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            exp_t x;
            x.cyc = e + 1 + n * len;
            x.idx = (n + PH) % 64;
            sb.push_back(x);
        end
    endtask

    task automatic pulse(input int p);
        period       = TR'(p);
        period_ready = 1'b1;
        tick(1);
        period_ready = 1'b0;
    endtask

    // Monitor: every accepted slice must match the queue head in cycle and index.
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_n_in && slice_valid && slice_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_slice idx=%0d cycle=%0d", slice_idx, cyc);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    if (x.cyc != cyc || x.idx != int'(slice_idx)) begin
                        fails++;
                        $display("FAIL slice actual idx=%0d cycle=%0d expected idx=%0d cycle=%0d",
                                 slice_idx, cyc, x.idx, x.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int e;
        int seq[6];
        rst_n_in     = 1'b0;
        period_ready = 1'b0;
        period       = '0;
        slice_ready  = 1'b1;
        tick(3);
        chk("rst_valid", slice_valid, 0);
        chk("rst_idx", slice_idx, 0);
        chk("rst_locked", locked, 0);
        chk("rst_overrun", overrun_count, 0);
        rst_n_in = 1'b1;
        tick(2);

        // Lock after four periods of 640. Slices come every 10 cycles.
        for (int i = 0; i < 4; i++) begin
            e = cyc;
            if (i == 3) push_rev(e, 10, 0, 63);
            pulse(640);
            chk($sformatf("lock_after_pulse%0d", i + 1), locked, (i == 3) ? 1 : 0);
            tick(639);
        end
        chk("no_slice_after_63", slice_valid, 0);
        chk("idx_hold_63", slice_idx, (63 + PH) % 64);

        // Period 645 still gives slice_len 10. Slice 63 absorbs 15 cycles.
        e = cyc;
        push_rev(e, 10, 0, 63);
        pulse(645);
        tick(644);
        chk("overrun_zero", overrun_count, 0);
        chk("last_slice_span", slice_idx, (63 + PH) % 64);

        // Consumer stalls for 25 cycles. Slices 1 and 2 replace pending ones.
        slice_ready = 1'b0;
        e = cyc;
        begin
            exp_t x;
            x.cyc = e + 25;
            x.idx = (2 + PH) % 64;
            sb.push_back(x);
        end
        push_rev(e, 10, 3, 62);
        pulse(640);
        chk("restart_idx0", slice_idx, PH);
        chk("restart_valid", slice_valid, 1);
        tick(24);
        chk("stall_idx2", slice_idx, (2 + PH) % 64);
        chk("stall_valid", slice_valid, 1);
        chk("stall_overrun", overrun_count, 2);
        slice_ready = 1'b1;
        tick(1);
        chk("accept_drops_valid", slice_valid, 0);
        tick(599);
        slice_ready = 1'b0;                 // leave slice 63 pending
        tick(1376);                         // cycle e+2001
        chk("wd_pre_locked", locked, 1);
        chk("wd_pre_valid", slice_valid, 1);
        tick(1);                            // cycle e+2002
        chk("wd_locked", locked, 0);
        chk("wd_valid", slice_valid, 0);
        chk("wd_overrun", overrun_count, 2);
        slice_ready = 1'b1;

        pulse(50);
        tick(9);
        chk("short_period_unlocked", locked, 0);

        // Acquisition with a jump: 640,640,800 restarts at 1, so three more 800s are needed.
        seq = '{640, 640, 800, 800, 800, 800};
        for (int i = 0; i < 6; i++) begin
            e = cyc;
            if (i == 5) push_rev(e, 12, 0, 4);
            pulse(seq[i]);
            chk($sformatf("acq_lock%0d", i + 1), locked, (i == 5) ? 1 : 0);
            if (i < 5) tick(seq[i] - 1);
        end
        tick(49);                           // cycle e+50
        slice_ready = 1'b0;
        tick(15);                           // cycle e+65, slice 5 pending
        chk("pre_rst_valid", slice_valid, 1);
        chk("pre_rst_idx", slice_idx, (5 + PH) % 64);
        chk("pre_rst_overrun", overrun_count, 2);
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_valid", slice_valid, 0);
        chk("async_rst_idx", slice_idx, 0);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_overrun", overrun_count, 0);
        tick(2);
        rst_n_in    = 1'b1;
        slice_ready = 1'b1;
        tick(2);
        chk("post_rst_valid", slice_valid, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
